// File: rtl/barrel_shift_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
// Shift modes and the pipeline depth calculation used by the top level.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shift_mode_e;

    // Number of stages needed to resolve log2(size) amount bits, bps at a time.
    function automatic int stage_num(input int size, input int bps);
        int log_size;
        int n;
        log_size = $clog2(size);
        n = (log_size + bps - 1) / bps;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One registered shifter stage: applies a slice of the amount and carries
// the per-word fields alongside the data.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int SIZE       = 32,
    parameter int USER_W     = 8,
    parameter int BITS       = 2,
    parameter int WEIGHT_LOG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [SIZE-1:0]          data_in,
    input  logic [$clog2(SIZE)-1:0]  amt_in,
    input  shift_mode_e              mode_in,
    input  logic                     sign_in,
    input  logic                     ovf_in,
    input  logic [USER_W-1:0]        user_in,
    input  logic                     valid_in,
    output logic [SIZE-1:0]          data_out,
    output logic [$clog2(SIZE)-1:0]  amt_out,
    output shift_mode_e              mode_out,
    output logic                     sign_out,
    output logic                     ovf_out,
    output logic [USER_W-1:0]        user_out,
    output logic                     valid_out
);

    localparam int LOG_SIZE = $clog2(SIZE);

    logic [LOG_SIZE-1:0] step;
    logic [SIZE-1:0]     fill;
    logic [SIZE-1:0]     shifted;
    logic [2*SIZE-1:0]   rot;

    always_comb begin
        step    = LOG_SIZE'(amt_in[WEIGHT_LOG +: BITS]) << WEIGHT_LOG;
        // Mask of the vacated high bits, used for sign fill on ASR.
        fill    = ~({SIZE{1'b1}} >> step);
        rot     = {data_in, data_in} >> step;
        shifted = data_in;
        case (mode_in)
            SH_LSL:  shifted = data_in << step;
            SH_LSR:  shifted = data_in >> step;
            SH_ASR:  shifted = (data_in >> step) | (sign_in ? fill : '0);
            SH_ROR:  shifted = rot[SIZE-1:0];
            default: shifted = data_in;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            amt_out   <= '0;
            mode_out  <= SH_LSL;
            sign_out  <= 1'b0;
            ovf_out   <= 1'b0;
            user_out  <= '0;
            valid_out <= 1'b0;
        end else if (en) begin
            data_out  <= shifted;
            amt_out   <= amt_in;
            mode_out  <= mode_in;
            sign_out  <= sign_in;
            ovf_out   <= ovf_in;
            user_out  <= user_in;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter with valid/ready flow control.
// Out-of-range amounts are saturated before stage 0; stages then shift by the low amount bits.
module barrel_shifter_pipe
    import barrel_shift_pkg::*;
#(
    parameter int SIZE           = 32,
    parameter int SHIFT_SIZE     = 8,
    parameter int BITS_PER_STAGE = 2,
    parameter int USER_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE-1:0]       din,
    input  logic [SHIFT_SIZE-1:0] shift,
    input  logic [1:0]            mode,
    input  logic [USER_W-1:0]     user_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE-1:0]       dout,
    output logic [USER_W-1:0]     user_out,
    output logic                  ovf
);

    localparam int LOG_SIZE  = $clog2(SIZE);
    localparam int STAGE_NUM = stage_num(SIZE, BITS_PER_STAGE);
    localparam int SA_W      = (SHIFT_SIZE < LOG_SIZE) ? SHIFT_SIZE : LOG_SIZE;

    logic                en;
    logic                in_ovf;
    shift_mode_e         in_mode;
    logic [SIZE-1:0]     sat_data;

    logic [SIZE-1:0]     data_pipe  [0:STAGE_NUM];
    logic [LOG_SIZE-1:0] amt_pipe   [0:STAGE_NUM];
    shift_mode_e         mode_pipe  [0:STAGE_NUM];
    logic                sign_pipe  [0:STAGE_NUM];
    logic                ovf_pipe   [0:STAGE_NUM];
    logic [USER_W-1:0]   user_pipe  [0:STAGE_NUM];
    logic                valid_pipe [0:STAGE_NUM];

    // Single global enable: the whole pipe advances unless the output is stalled.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign in_mode  = shift_mode_e'(mode);

    generate
        if (SHIFT_SIZE > LOG_SIZE) begin : g_ovf
            assign in_ovf = |shift[SHIFT_SIZE-1:LOG_SIZE];
        end else begin : g_no_ovf
            assign in_ovf = 1'b0;
        end
    endgenerate

    // Saturated values are fixed points of the later shifts, so the amount can stay as-is.
    always_comb begin
        sat_data = din;
        if (in_ovf) begin
            case (in_mode)
                SH_LSL, SH_LSR: sat_data = '0;
                SH_ASR:         sat_data = {SIZE{din[SIZE-1]}};
                default:        sat_data = din;
            endcase
        end
    end

    assign data_pipe[0]  = sat_data;
    assign amt_pipe[0]   = LOG_SIZE'(shift[SA_W-1:0]);
    assign mode_pipe[0]  = in_mode;
    assign sign_pipe[0]  = din[SIZE-1];
    assign ovf_pipe[0]   = in_ovf;
    assign user_pipe[0]  = user_in;
    assign valid_pipe[0] = in_valid;

    generate
        for (genvar gi = 0; gi < STAGE_NUM; gi++) begin : g_stage
            localparam int REMAIN = LOG_SIZE - gi * BITS_PER_STAGE;
            localparam int BITS   = (REMAIN < BITS_PER_STAGE) ? REMAIN : BITS_PER_STAGE;

            barrel_shift_stage #(
                .SIZE       (SIZE),
                .USER_W     (USER_W),
                .BITS       (BITS),
                .WEIGHT_LOG (gi * BITS_PER_STAGE)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .data_in   (data_pipe[gi]),
                .amt_in    (amt_pipe[gi]),
                .mode_in   (mode_pipe[gi]),
                .sign_in   (sign_pipe[gi]),
                .ovf_in    (ovf_pipe[gi]),
                .user_in   (user_pipe[gi]),
                .valid_in  (valid_pipe[gi]),
                .data_out  (data_pipe[gi+1]),
                .amt_out   (amt_pipe[gi+1]),
                .mode_out  (mode_pipe[gi+1]),
                .sign_out  (sign_pipe[gi+1]),
                .ovf_out   (ovf_pipe[gi+1]),
                .user_out  (user_pipe[gi+1]),
                .valid_out (valid_pipe[gi+1])
            );
        end
    endgenerate

    assign out_valid = valid_pipe[STAGE_NUM];
    assign dout      = data_pipe[STAGE_NUM];
    assign user_out  = user_pipe[STAGE_NUM];
    assign ovf       = ovf_pipe[STAGE_NUM];

    logic unused_tail;
    assign unused_tail = ^{amt_pipe[STAGE_NUM], mode_pipe[STAGE_NUM], sign_pipe[STAGE_NUM]};

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed and random checks of barrel_shifter_pipe in three configurations.
// Main instance is scoreboarded by a negedge monitor; sweep instances are checked inline.
module tb_barrel_shifter_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Main instance: SIZE=32, SHIFT_SIZE=8, BITS_PER_STAGE=2
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf;
    logic [31:0] din = '0, dout;
    logic [7:0]  shift = '0, user_in = '0, user_out;
    logic [1:0]  mode = '0;

    barrel_shifter_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .shift(shift), .mode(mode), .user_in(user_in), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .user_out(user_out), .ovf(ovf)
    );

    // Sweep A: SIZE=64, BITS_PER_STAGE=1 (6 stages)
    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_ovf;
    logic        a_out_ready = 1'b1;
    logic [63:0] a_din = '0, a_dout;
    logic [7:0]  a_shift = '0, a_user_in = '0, a_user_out;
    logic [1:0]  a_mode = '0;

    barrel_shifter_pipe #(.SIZE(64), .SHIFT_SIZE(8), .BITS_PER_STAGE(1), .USER_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .shift(a_shift), .mode(a_mode), .user_in(a_user_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .dout(a_dout), .user_out(a_user_out), .ovf(a_ovf)
    );

    // Sweep B: SIZE=8, SHIFT_SIZE=2 (2 stages, no overflow possible)
    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_ovf;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_din = '0, b_dout;
    logic [1:0]  b_shift = '0;
    logic [7:0]  b_user_in = '0, b_user_out;
    logic [1:0]  b_mode = '0;

    barrel_shifter_pipe #(.SIZE(8), .SHIFT_SIZE(2), .BITS_PER_STAGE(2), .USER_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .shift(b_shift), .mode(b_mode), .user_in(b_user_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .dout(b_dout), .user_out(b_user_out), .ovf(b_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: amount taken modulo size, saturation when shift >= size.
    function automatic logic [63:0] model(input logic [63:0] d_in, input int sh, input int m,
                                          input int size);
        logic [63:0] mask, d, r;
        logic        sgn, ov;
        int          sa;
        mask = (size == 64) ? '1 : ((64'd1 << size) - 64'd1);
        d    = d_in & mask;
        sgn  = d[size-1];
        ov   = (sh >= size);
        sa   = sh % size;
        case (m)
            0:       r = ov ? 64'd0 : (d << sa);
            1:       r = ov ? 64'd0 : (d >> sa);
            2:       r = ov ? (sgn ? mask : 64'd0)
                            : ((d >> sa) | (sgn ? (mask & ~(mask >> sa)) : 64'd0));
            default: r = (d >> sa) | (d << (size - sa));
        endcase
        return r & mask;
    endfunction

    // Scoreboard for the main instance
    typedef struct packed {
        logic [31:0] d;
        logic        o;
        logic [7:0]  u;
    } exp_t;

    exp_t        exp_q[$];
    int          n_in = 0, n_out = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d;
    logic [7:0]  held_u;
    logic        held_o;

    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] r;
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_dout", 64'(dout), 64'(held_d));
                chk("stall_user", 64'(user_out), 64'(held_u));
                chk("stall_ovf", 64'(ovf), 64'(held_o));
            end
            held_v = out_valid && !out_ready;
            held_d = dout;
            held_u = user_out;
            held_o = ovf;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dout", 64'(dout), 64'(e.d));
                    chk("sb_ovf", 64'(ovf), 64'(e.o));
                    chk("sb_user", 64'(user_out), 64'(e.u));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                r   = model(64'(din), int'(shift), int'(mode), 32);
                e.d = r[31:0];
                e.o = (shift >= 8'd32);
                e.u = user_in;
                exp_q.push_back(e);
                n_in++;
            end
        end
    end

    // One word through an empty pipe; checks exact 3-cycle latency and result.
    task automatic directed(input string tag, input logic [31:0] d, input int sh, input int m,
                            input logic [7:0] u, input logic [31:0] exp_d, input logic exp_o);
        @(posedge clk); #2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din       = d;
        shift     = 8'(sh);
        mode      = 2'(m);
        user_in   = u;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
            @(negedge clk);
            if (i < 3) begin
                chk({tag, "_early"}, 64'(out_valid), 64'd0);
            end else begin
                chk({tag, "_valid"}, 64'(out_valid), 64'd1);
                chk({tag, "_dout"}, 64'(dout), 64'(exp_d));
                chk({tag, "_ovf"}, 64'(ovf), 64'(exp_o));
                chk({tag, "_user"}, 64'(user_out), 64'(u));
            end
        end
    endtask

    localparam int NS = 40;
    logic [63:0] a_exp [NS];
    logic        a_eo  [NS];
    logic [7:0]  a_eu  [NS];
    logic [7:0]  b_exp [NS];
    logic [1:0]  b_m   [NS];
    logic [7:0]  b_eu  [NS];

    initial begin
        int in0, out0, sh;
        logic [63:0] r;

        // Reset state
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_user", 64'(user_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk("post_rst_valid", 64'(out_valid), 64'd0);

        // Modes and overflow
        directed("lsl31",   32'h00000001, 31,  0, 8'hA1, 32'h80000000, 1'b0);
        directed("lsr31",   32'h80000000, 31,  1, 8'hA2, 32'h00000001, 1'b0);
        directed("asr4",    32'h80000000, 4,   2, 8'hA3, 32'hF8000000, 1'b0);
        directed("ror4",    32'h000000F1, 4,   3, 8'hA4, 32'h1000000F, 1'b0);
        directed("lsr32",   32'hFFFFFFFF, 32,  1, 8'hB1, 32'h00000000, 1'b1);
        directed("asr200",  32'h80000001, 200, 2, 8'hB2, 32'hFFFFFFFF, 1'b1);
        directed("ror36",   32'h000000F1, 36,  3, 8'hB3, 32'h1000000F, 1'b1);
        directed("asr40p",  32'h7FFFFFFF, 40,  2, 8'hB4, 32'h00000000, 1'b1);
        directed("lsl33",   32'h00000003, 33,  0, 8'hB5, 32'h00000000, 1'b1);
        directed("lsl0",    32'h12345678, 0,   0, 8'hC1, 32'h12345678, 1'b0);
        directed("asr0",    32'h87654321, 0,   2, 8'hC2, 32'h87654321, 1'b0);

        // Streaming: 100 back-to-back words
        @(posedge clk); #2;
        in0 = n_in; out0 = n_out;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            din      = $urandom;
            sh       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, 31));
            shift    = 8'(sh);
            mode     = 2'($urandom);
            user_in  = 8'($urandom);
            if (c == 53) chk("stream_rate", 64'(n_out - out0), 64'd50);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("stream_in", 64'(n_in - in0), 64'd100);
        chk("stream_out", 64'(n_out - out0), 64'd100);

        // Backpressure with input gaps
        in0 = n_in; out0 = n_out;
        for (int c = 0; c < 300; c++) begin
            out_ready = $urandom_range(0, 1) == 1;
            in_valid  = $urandom_range(0, 2) != 0;
            din       = $urandom;
            shift     = 8'($urandom_range(0, 40));
            mode      = 2'($urandom);
            user_in   = 8'($urandom);
            @(posedge clk); #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        chk("bp_count", 64'(n_out - out0), 64'(n_in - in0));
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with three words in flight
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            din      = 32'h00000100 << i;
            shift    = 8'd1;
            mode     = 2'd0;
            user_in  = 8'(8'h50 + i);
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_dout", 64'(dout), 64'd0);
        chk("arst_user", 64'(user_out), 64'd0);
        chk("arst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_release_valid", 64'(out_valid), 64'd0);
        directed("after_rst", 32'h00000003, 1, 0, 8'h77, 32'h00000006, 1'b0);

        // Parameter sweep: both alternate instances stream in lockstep
        for (int c = 0; c < NS + 7; c++) begin
            @(posedge clk); #2;
            if (c < NS) begin
                a_in_valid = 1'b1;
                a_din      = {$urandom, $urandom};
                a_shift    = 8'($urandom_range(0, 80));
                a_mode     = 2'($urandom);
                a_user_in  = 8'($urandom);
                a_exp[c]   = model(a_din, int'(a_shift), int'(a_mode), 64);
                a_eo[c]    = (a_shift >= 8'd64);
                a_eu[c]    = a_user_in;
                b_in_valid = 1'b1;
                b_din      = 8'($urandom);
                b_shift    = 2'($urandom);
                b_mode     = 2'($urandom);
                b_user_in  = 8'($urandom);
                r          = model(64'(b_din), int'(b_shift), int'(b_mode), 8);
                b_exp[c]   = r[7:0];
                b_m[c]     = b_mode;
                b_eu[c]    = b_user_in;
            end else begin
                a_in_valid = 1'b0;
                b_in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 6) begin
                chk("a_latency", 64'(a_out_valid), 64'd0);
            end else if (c - 6 < NS) begin
                chk("a_valid", 64'(a_out_valid), 64'd1);
                chk("a_dout", a_dout, a_exp[c-6]);
                chk("a_ovf", 64'(a_ovf), 64'(a_eo[c-6]));
                chk("a_user", 64'(a_user_out), 64'(a_eu[c-6]));
            end
            if (c < 2) begin
                chk("b_latency", 64'(b_out_valid), 64'd0);
            end else if (c - 2 < NS) begin
                chk("b_valid", 64'(b_out_valid), 64'd1);
                chk("b_dout", 64'(b_dout), 64'(b_exp[c-2]));
                chk("b_user", 64'(b_user_out), 64'(b_eu[c-2]));
            end
            chk("b_ovf_never", 64'(b_ovf), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Pipelined, multi-mode barrel shifter with a valid/ready handshake, for datapaths that need to insert it into a streaming pipeline rather than run it free. It supports logical left, logical right, arithmetic right and rotate right. It resolves the shift amount in configurable radix per stage and carries a user sideband alongside each word. Out-of-range amounts saturate: zero for the logical modes, sign fill for arithmetic right.

## Interface
- SIZE, 32: data width; power of two, ≥4.
- SHIFT_SIZE, 8: width of shift amount; any value ≥1.
- BITS_PER_STAGE, 2: shift-amount bits resolved per pipeline stage; 1..4.
- USER_W, 8: sideband width, passed through unchanged.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block accepts input this cycle.
- din  in  SIZE  data to shift.
- shift  in  SHIFT_SIZE  unsigned shift amount.
- mode  in  2  0=LSL, 1=LSR, 2=ASR, 3=ROR.
- user_in  in  USER_W  sideband.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- dout  out  SIZE  shifted result.
- user_out  out  USER_W  sideband of the same transaction.
- ovf  out  1  shift ≥ SIZE for this result; reported in every mode, including ROR.

## Operation
- LOG_SIZE = log2(SIZE).
- SA = min(SHIFT_SIZE, LOG_SIZE) low bits of shift are the effective amount.
- ovf = any shift bit at or above position LOG_SIZE is set; computed at input, carried with the word.
- LSL/LSR: ovf → result 0; otherwise shift by SA, zero fill.
- ASR: ovf → all bits equal din[SIZE-1]; otherwise shift right by SA, filling with din[SIZE-1].
- ROR: rotate right by SA, i.e. shift mod SIZE; ovf does not alter data.
- STAGE_NUM = max(1, ceil(LOG_SIZE / BITS_PER_STAGE)).
- Stage k applies amount bits [k·BITS_PER_STAGE +: BITS_PER_STAGE] (last stage takes the remainder), weighted by 2^(k·BITS_PER_STAGE).
- Mode, original sign bit, ovf and user travel in lockstep with the data through every stage.
- Flow control uses one global enable: en = ~out_valid | out_ready.
  - When en=1, every stage captures from its predecessor, and the valid bits shift.
  - When en=0, all stages hold.
  - in_ready = en, a combinational path from out_ready.
  - Bubbles are not collapsed.
- Transfer happens when valid & ready on the same edge; inputs with in_valid=0 insert a bubble (valid bit 0).

## Timing
- Latency: exactly STAGE_NUM cycles from input transfer to out_valid, absent stalls. Default is 3 cycles.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 → in_ready=0 the same cycle.
  - dout/user_out/ovf remain stable until transferred.
  - No word is lost or duplicated.
- out_valid, dout, user_out and ovf are registered outputs.
- Reset: asynchronous assertion clears all stage valid bits and data/sideband registers.
  - out_valid=0, dout=0, user_out=0, ovf=0 while rst=1 and after release.
  - in_ready=1 after release.
  - Reset mid-stream discards all in-flight words.
- shift=0 → dout=din in all modes.
- SHIFT_SIZE < LOG_SIZE → ovf is constant 0.

## Structure
- Package barrel_shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_e {SH_LSL, SH_LSR, SH_ASR, SH_ROR};
  - function stage_num(size, bps) returning STAGE_NUM.
- Sub-module barrel_shift_stage holds one registered stage:
  - parameters SIZE, USER_W, BITS, WEIGHT_LOG;
  - inputs en, partial data, amount slice, mode, sign, ovf, user, valid;
  - registered outputs of the same fields.
- The top instantiates STAGE_NUM stages in a generate loop and computes ovf/saturation before stage 0.

## Test plan
- Modes, SIZE=32, out_ready=1:
  - LSL 0x00000001 by 31 → 0x80000000;
  - LSR 0x80000000 by 31 → 0x00000001;
  - ASR 0x80000000 by 4 → 0xF8000000;
  - ROR 0x000000F1 by 4 → 0x1000000F.
  - Each appears 3 cycles after transfer.
- Overflow:
  - LSR 0xFFFFFFFF by 32 → 0, ovf=1;
  - ASR 0x80000001 by 200 → 0xFFFFFFFF, ovf=1;
  - ROR 0x000000F1 by 36 → 0x1000000F, ovf=1.
- Streaming: 100 random words back-to-back with random mode/shift/user → outputs match a reference model in order, one per cycle, with user_out matched.
- Backpressure: random out_ready (50%), random in_valid gaps → no loss/duplication; dout is stable during each stall; in_ready equals ~out_valid | out_ready on every cycle.
- Reset: assert rst asynchronously with 3 words in flight → out_valid and dout drop to 0 immediately; after release, a new word LSL 0x3 by 1 → 0x6 after 3 cycles, with no stale outputs.
- Parameter sweep:
  - SIZE=64, BITS_PER_STAGE=1 → latency 6;
  - SIZE=8, SHIFT_SIZE=2 → latency 2, ovf never set.
  - Random checks pass in both configurations.
